// File: rtl/read_superpixel.sv
// Read-back engine for the VGA frame buffer: scans one logical superpixel through the
// RAM read port and reports its top-left colour, a reference-colour hit count and uniformity.
module read_superpixel #(
  parameter int SPIXEL_X_WIDTH = 5,
  parameter int SPIXEL_Y_WIDTH = 5,
  parameter int SPIXEL_X_MAX   = 31,
  parameter int SPIXEL_Y_MAX   = 23,
  parameter int PIXEL_X_WIDTH  = 10,
  parameter int PIXEL_Y_WIDTH  = 9,
  parameter int PIXEL_X_MAX    = 639,
  parameter int PIXEL_Y_MAX    = 479,
  parameter int SP_W           = (PIXEL_X_MAX + 1) / (SPIXEL_X_MAX + 1),
  parameter int SP_H           = (PIXEL_Y_MAX + 1) / (SPIXEL_Y_MAX + 1),
  parameter int VGA_ADDR_WIDTH = 19,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int RD_LATENCY     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SPIXEL_X_WIDTH-1:0] x,
  input  logic [SPIXEL_Y_WIDTH-1:0] y,
  input  logic [COLOR_ID_WIDTH-1:0] idata,
  input  logic                      idata_vld,
  output logic                      obusy,
  output logic                      odone,
  output logic [COLOR_ID_WIDTH-1:0] ocolor,
  output logic [8:0]                ohit_cnt,
  output logic                      ouniform,
  output logic                      oerr,
  output logic [VGA_ADDR_WIDTH-1:0] oaddr,
  output logic                      ordren,
  input  logic [COLOR_ID_WIDTH-1:0] irdata
);

  localparam int COL_W = $clog2(SP_W + 1);
  localparam int ROW_W = $clog2(SP_H + 1);
  localparam logic [VGA_ADDR_WIDTH-1:0] STRIDE = VGA_ADDR_WIDTH'(PIXEL_X_MAX + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SP_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SP_H - 1);
  localparam logic [RD_LATENCY-1:0] LAST_ONLY = RD_LATENCY'(1) << (RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [RD_LATENCY-1:0]     rd_pipe;
  logic [COLOR_ID_WIDTH-1:0] ref_color;
  logic                      first_seen;
  logic [VGA_ADDR_WIDTH-1:0] row_start;
  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic [PIXEL_X_WIDTH-1:0]  px0;
  logic [PIXEL_Y_WIDTH-1:0]  py0;
  logic [VGA_ADDR_WIDTH-1:0] base;
  logic                      in_range;
  logic                      accept;
  logic                      last_read;
  logic                      rd_vld;

  // Top-left physical pixel of the requested superpixel, then its linear address.
  assign px0  = PIXEL_X_WIDTH'(x) * PIXEL_X_WIDTH'(SP_W);
  assign py0  = PIXEL_Y_WIDTH'(y) * PIXEL_Y_WIDTH'(SP_H);
  assign base = VGA_ADDR_WIDTH'(py0) * STRIDE + VGA_ADDR_WIDTH'(px0);

  assign in_range  = ({1'b0, x} <= (SPIXEL_X_WIDTH + 1)'(SPIXEL_X_MAX)) &&
                     ({1'b0, y} <= (SPIXEL_Y_WIDTH + 1)'(SPIXEL_Y_MAX));
  assign accept    = (state == IDLE) && idata_vld;
  assign last_read = (state == READ) && (col == LAST_COL) && (row == LAST_ROW);
  assign rd_vld    = rd_pipe[RD_LATENCY-1];

  assign ordren = (state == READ);
  assign obusy  = (state != IDLE);
  assign odone  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // DRAIN ends when only the final return is left in the pipe and it is being sampled now.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (idata_vld) state_next = in_range ? READ : DONE;
      READ:    if (last_read) state_next = DRAIN;
      DRAIN:   if (rd_pipe == LAST_ONLY) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= ordren;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_color  <= '0;
      first_seen <= 1'b0;
      ocolor     <= '0;
      ohit_cnt   <= '0;
      ouniform   <= 1'b0;
      oerr       <= 1'b0;
      oaddr      <= '0;
      row_start  <= '0;
      col        <= '0;
      row        <= '0;
    end else if (accept) begin
      ref_color  <= idata;
      first_seen <= 1'b0;
      ocolor     <= '0;
      ohit_cnt   <= '0;
      ouniform   <= in_range;
      oerr       <= !in_range;
      oaddr      <= base;
      row_start  <= base;
      col        <= '0;
      row        <= '0;
    end else begin
      if (ordren) begin
        if (col == LAST_COL) begin
          col       <= '0;
          row       <= row + ROW_W'(1);
          row_start <= row_start + STRIDE;
          oaddr     <= row_start + STRIDE;
        end else begin
          col   <= col + COL_W'(1);
          oaddr <= oaddr + VGA_ADDR_WIDTH'(1);
        end
      end
      if (rd_vld) begin
        if (!first_seen) begin
          ocolor     <= irdata;
          first_seen <= 1'b1;
        end else if (irdata != ocolor) begin
          ouniform <= 1'b0;
        end
        if (irdata == ref_color) ohit_cnt <= ohit_cnt + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_read_superpixel.sv
// Bench for read_superpixel: three instances (read latency 1, 2, 3) share one RAM image
// and are checked every cycle against a superpixel-level model of the scan.
module tb_read_superpixel;

  localparam int NREADS = 400;
  localparam int NEVER  = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] x = '0;
  logic [4:0] y = '0;
  logic [7:0] idata = '0;
  logic       idata_vld = 1'b0;

  logic        obusy [3];
  logic        odone [3];
  logic        ouniform [3];
  logic        oerr [3];
  logic        ordren [3];
  logic [7:0]  ocolor [3];
  logic [7:0]  irdata [3];
  logic [8:0]  ohit_cnt [3];
  logic [18:0] oaddr [3];

  logic [7:0] mem [0:307199];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  bit       req_active = 1'b0;
  bit       req_err = 1'b0;
  int       acc_cyc = 0;
  int       zero_from = NEVER;
  int       exp_base = 0;
  logic [7:0] exp_color = '0;
  int       exp_hits = 0;
  bit       exp_uni = 1'b0;

  int ndone [3];
  int done_t [3];
  int nrd [3];
  int first_a [3];
  int last_a [3];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    logic [7:0] rq [0:2];
    // Synchronous RAM with read latency g+1, read every cycle at the current address.
    always @(posedge clk) begin
      rq[0] <= (oaddr[g] < 19'd307200) ? mem[oaddr[g]] : 8'h00;
      for (int j = 1; j < 3; j++) rq[j] <= rq[j-1];
    end
    assign irdata[g] = rq[g];

    read_superpixel #(.RD_LATENCY(g + 1)) u_dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .idata(idata), .idata_vld(idata_vld),
      .obusy(obusy[g]), .odone(odone[g]), .ocolor(ocolor[g]), .ohit_cnt(ohit_cnt[g]),
      .ouniform(ouniform[g]), .oerr(oerr[g]), .oaddr(oaddr[g]), .ordren(ordren[g]),
      .irdata(irdata[g])
    );
  end

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s lat%0d cyc%0d: got %0d expected %0d", name, k + 1, cyc, act, exp);
    end
  endtask

  // Model: what a superpixel scan must report, computed straight from the RAM image.
  task automatic modelRequest(input int rx, input int ry, input logic [7:0] rc);
    req_err = (rx > 31) || (ry > 23);
    exp_base = (ry * 20) * 640 + rx * 20;
    if (req_err) begin
      exp_color = 8'h00; exp_hits = 0; exp_uni = 1'b0;
    end else begin
      exp_color = mem[exp_base];
      exp_hits = 0;
      exp_uni = 1'b1;
      for (int r = 0; r < 20; r++)
        for (int c = 0; c < 20; c++) begin
          if (mem[exp_base + r * 640 + c] == rc) exp_hits++;
          if (mem[exp_base + r * 640 + c] != exp_color) exp_uni = 1'b0;
        end
    end
  endtask

  task automatic applyStimulus(input int rx, input int ry, input logic [7:0] rc);
    @(posedge clk); #1;
    x = 5'(rx); y = 5'(ry); idata = rc; idata_vld = 1'b1;
    modelRequest(rx, ry, rc);
    acc_cyc = cyc;
    zero_from = NEVER;
    req_active = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ndone[k] = 0; done_t[k] = -1; nrd[k] = 0; first_a[k] = -1; last_a[k] = -1;
    end
    @(posedge clk); #1;
    idata_vld = 1'b0;
  endtask

  task automatic waitAllDone();
    for (int i = 0; i < 700 && !(ndone[0] > 0 && ndone[1] > 0 && ndone[2] > 0); i++)
      @(posedge clk);
    n_checks++;
    if (!(ndone[0] > 0 && ndone[1] > 0 && ndone[2] > 0)) begin
      n_errors++;
      $display("[TB] FAIL done_timeout: got done counts %0d/%0d/%0d expected all nonzero",
               ndone[0], ndone[1], ndone[2]);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every instance against the model schedule.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int k = 0; k < 3; k++) begin
        int t;
        int lat;
        bit e_rd, e_done, e_busy, e_res;
        lat = k + 1;
        t = cyc - acc_cyc;
        if (!req_active || cyc >= zero_from) begin
          checkOutput("idle_ordren", k, ordren[k], 0);
          checkOutput("idle_obusy", k, obusy[k], 0);
          checkOutput("idle_odone", k, odone[k], 0);
          checkOutput("idle_oaddr", k, oaddr[k], 0);
          checkOutput("idle_ocolor", k, ocolor[k], 0);
          checkOutput("idle_hits", k, ohit_cnt[k], 0);
          checkOutput("idle_uniform", k, ouniform[k], 0);
          checkOutput("idle_oerr", k, oerr[k], 0);
        end else begin
          if (req_err) begin
            e_rd = 1'b0; e_done = (t == 1); e_busy = (t == 1); e_res = (t >= 1);
          end else begin
            e_rd   = (t >= 1) && (t <= NREADS);
            e_done = (t == NREADS + lat + 1);
            e_busy = (t >= 1) && (t <= NREADS + lat + 1);
            e_res  = (t >= NREADS + lat + 1);
          end
          checkOutput("ordren", k, ordren[k], e_rd);
          checkOutput("odone", k, odone[k], e_done);
          checkOutput("obusy", k, obusy[k], e_busy);
          if (e_rd)
            checkOutput("oaddr", k, oaddr[k], exp_base + ((t - 1) / 20) * 640 + (t - 1) % 20);
          if (e_res) begin
            checkOutput("ocolor", k, ocolor[k], exp_color);
            checkOutput("hits", k, ohit_cnt[k], exp_hits);
            checkOutput("uniform", k, ouniform[k], exp_uni);
            checkOutput("oerr", k, oerr[k], req_err);
          end
        end
        if (odone[k] === 1'b1) begin
          ndone[k]++;
          done_t[k] = t;
        end
        if (ordren[k] === 1'b1) begin
          if (nrd[k] == 0) first_a[k] = oaddr[k];
          last_a[k] = oaddr[k];
          nrd[k]++;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 307200; i++) mem[i] = 8'h0f;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Uniform superpixel at the origin.
    applyStimulus(0, 0, 8'h0f);
    waitAllDone();
    for (int k = 0; k < 3; k++) begin
      checkOutput("s1_done_cycle", k, done_t[k], 402 + k);
      checkOutput("s1_hits_lit", k, ohit_cnt[k], 400);
      checkOutput("s1_uniform_lit", k, ouniform[k], 1);
      checkOutput("s1_color_lit", k, ocolor[k], 8'h0f);
      checkOutput("s1_last_addr", k, last_a[k], 12179);
      checkOutput("s1_reads", k, nrd[k], 400);
    end

    // Superpixel (5,3) filled with ff except one pixel.
    for (int r = 60; r < 80; r++)
      for (int c = 100; c < 120; c++) mem[r * 640 + c] = 8'hff;
    mem[50679] = 8'h0f;
    applyStimulus(5, 3, 8'hff);
    waitAllDone();
    for (int k = 0; k < 3; k++) begin
      checkOutput("s2_hits_lit", k, ohit_cnt[k], 399);
      checkOutput("s2_uniform_lit", k, ouniform[k], 0);
      checkOutput("s2_color_lit", k, ocolor[k], 8'hff);
      checkOutput("s2_first_addr", k, first_a[k], 38500);
    end

    // Same superpixel counting the odd pixel's colour.
    applyStimulus(5, 3, 8'h0f);
    waitAllDone();
    for (int k = 0; k < 3; k++) checkOutput("s3_hits_lit", k, ohit_cnt[k], 1);

    // Bottom-right corner of the frame.
    applyStimulus(31, 23, 8'h0f);
    waitAllDone();
    for (int k = 0; k < 3; k++) begin
      checkOutput("corner_first", k, first_a[k], 295020);
      checkOutput("corner_last", k, last_a[k], 307199);
      checkOutput("corner_reads", k, nrd[k], 400);
      checkOutput("corner_ndone", k, ndone[k], 1);
    end

    // Row out of range.
    applyStimulus(0, 24, 8'h0f);
    waitAllDone();
    for (int k = 0; k < 3; k++) begin
      checkOutput("err_done_cycle", k, done_t[k], 1);
      checkOutput("err_oerr_lit", k, oerr[k], 1);
      checkOutput("err_hits_lit", k, ohit_cnt[k], 0);
      checkOutput("err_reads", k, nrd[k], 0);
    end

    // Strobe while busy must be ignored.
    applyStimulus(1, 1, 8'h0f);
    repeat (49) @(posedge clk);
    #1;
    x = 5'd7; y = 5'd7; idata = 8'h11; idata_vld = 1'b1;
    @(posedge clk); #1;
    idata_vld = 1'b0;
    waitAllDone();
    repeat (10) @(posedge clk);
    for (int k = 0; k < 3; k++) checkOutput("busy_strobe_ndone", k, ndone[k], 1);

    // Reset in the middle of a scan aborts it silently.
    applyStimulus(2, 2, 8'h0f);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    zero_from = cyc + 1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("rst_ndone", k, ndone[k], 0);
      checkOutput("rst_reads", k, nrd[k], 100);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
